// File: rtl/network_host_if.sv
// network_host_if: requester-side job/response handshake of network_host.
// The requester drives the master modport, the host uses the slave modport.
interface network_host_if #(
    parameter int INPUT_SIZE  = 2,
    parameter int OUTPUT_SIZE = 1
);
    logic               req_valid;
    logic               req_ready;
    logic signed [31:0] req_data [0:INPUT_SIZE-1];
    logic               resp_valid;
    logic               resp_ready;
    logic signed [31:0] resp_data [0:OUTPUT_SIZE-1];
    logic               resp_timeout;

    modport master (
        output req_valid,
        output req_data,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  resp_data,
        input  resp_timeout
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output resp_data,
        output resp_timeout
    );
endinterface

// File: rtl/network_host.sv
// network_host: accepts one job at a time from a requester, hands the operands
// to a network controller, waits for its finish flag (or a timeout), waits for
// the controller to return to idle, then presents the captured result until
// the requester takes it.
module network_host #(
    parameter int INPUT_SIZE  = 2,
    parameter int OUTPUT_SIZE = 1,
    parameter int TIMEOUT     = 1024
) (
    input  logic               clk,
    input  logic               n_rst,
    network_host_if.slave      host_bus,
    output logic [7:0]         ctrl_to_net,
    input  logic [7:0]         ctrl_from_net,
    output logic signed [31:0] net_data_in [0:INPUT_SIZE-1],
    input  logic signed [31:0] net_data_out [0:OUTPUT_SIZE-1],
    output logic               busy
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FINISH,
        RELEASE,
        RESPOND
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);
    localparam logic [15:0] CNT_MAX  = 16'hFFFF;

    state_t      state;
    logic [15:0] cnt;
    logic        start_q;

    logic net_finish;
    logic net_idle;
    assign net_finish = ctrl_from_net[0];
    assign net_idle   = (ctrl_from_net[7:6] == 2'b00);

    // Status bits 5:1 carry nothing the host acts on.
    logic unused_status;
    assign unused_status = ^ctrl_from_net[5:1];

    // Start is a registered copy of "state is WAIT_FINISH", so it rises the
    // cycle after acceptance and drops with the state change or reset.
    assign ctrl_to_net = {7'b000_0000, start_q};

    // Job sequencer: state, registered handshake outputs, timeout counter,
    // operand registers and captured result all update together.
    // NOTE: every register here is assigned with <= so all of them see the
    // pre-edge values of each other; a blocking = would leak same-cycle updates.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            // NOTE: the operand and result arrays are reset explicitly because
            // their cleared value is architecturally visible (a timeout right
            // after reset reports resp_data = 0).
            state                 <= IDLE;
            cnt                   <= '0;
            start_q               <= 1'b0;
            busy                  <= 1'b0;
            host_bus.req_ready    <= 1'b1;
            host_bus.resp_valid   <= 1'b0;
            host_bus.resp_timeout <= 1'b0;
            for (int i = 0; i < INPUT_SIZE; i++) begin
                net_data_in[i] <= '0;
            end
            for (int i = 0; i < OUTPUT_SIZE; i++) begin
                host_bus.resp_data[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (host_bus.req_valid) begin
                        for (int i = 0; i < INPUT_SIZE; i++) begin
                            net_data_in[i] <= host_bus.req_data[i];
                        end
                        cnt                <= '0;
                        state              <= WAIT_FINISH;
                        start_q            <= 1'b1;
                        busy               <= 1'b1;
                        host_bus.req_ready <= 1'b0;
                    end
                end

                WAIT_FINISH: begin
                    // A finish seen on the last allowed cycle still counts.
                    if (net_finish) begin
                        for (int i = 0; i < OUTPUT_SIZE; i++) begin
                            host_bus.resp_data[i] <= net_data_out[i];
                        end
                        host_bus.resp_timeout <= 1'b0;
                        cnt                   <= '0;
                        state                 <= RELEASE;
                        start_q               <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        host_bus.resp_timeout <= 1'b1;
                        cnt                   <= '0;
                        state                 <= RELEASE;
                        start_q               <= 1'b0;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 16'd1;
                    end
                end

                RELEASE: begin
                    if (!net_finish && net_idle) begin
                        state               <= RESPOND;
                        host_bus.resp_valid <= 1'b1;
                    end else if (cnt == CNT_LAST) begin
                        host_bus.resp_timeout <= 1'b1;
                        state                 <= RESPOND;
                        host_bus.resp_valid   <= 1'b1;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 16'd1;
                    end
                end

                RESPOND: begin
                    if (host_bus.resp_ready) begin
                        state               <= IDLE;
                        host_bus.resp_valid <= 1'b0;
                        host_bus.req_ready  <= 1'b1;
                        busy                <= 1'b0;
                    end
                end

                default: begin
                    state               <= IDLE;
                    start_q             <= 1'b0;
                    busy                <= 1'b0;
                    host_bus.req_ready  <= 1'b1;
                    host_bus.resp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_network_host.sv
// tb_network_host: directed jobs against network_host with a behavioural
// network controller and a transaction-level expectation model.
module tb_network_host;

    localparam int INPUT_SIZE  = 2;
    localparam int OUTPUT_SIZE = 1;
    localparam int TIMEOUT     = 1024;

    logic               clk = 1'b0;
    logic               n_rst;
    logic [7:0]         ctrl_to_net;
    logic [7:0]         ctrl_from_net;
    logic signed [31:0] net_data_in [0:INPUT_SIZE-1];
    logic signed [31:0] net_data_out [0:OUTPUT_SIZE-1];
    logic               busy;

    network_host_if #(.INPUT_SIZE(INPUT_SIZE), .OUTPUT_SIZE(OUTPUT_SIZE)) bus ();

    network_host #(
        .INPUT_SIZE (INPUT_SIZE),
        .OUTPUT_SIZE(OUTPUT_SIZE),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .host_bus     (bus),
        .ctrl_to_net  (ctrl_to_net),
        .ctrl_from_net(ctrl_from_net),
        .net_data_in  (net_data_in),
        .net_data_out (net_data_out),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Directed job table: operands, controller behaviour, requester behaviour
    // and hand-computed response.
    typedef struct {
        int op0;
        int op1;
        int fin;      // start cycle (1-based) on which finish shows; 0 = never
        int stall;    // cycles the controller reports state 2'b10 after start drops
        int delay;    // extra RESPOND cycles with resp_ready low
        bit hold;     // keep req_valid high through the job (next job queued)
        int exp_data;
        bit exp_to;
    } job_t;

    job_t jobs [0:8];

    // Controller configuration for the job being presented.
    int cur_fin   = 0;
    int cur_stall = 0;

    // Behavioural network controller, driven away from the active edge.
    int         c_start_cnt = 0;
    int         c_rel_cnt   = 0;
    logic       c_fin;
    logic [1:0] c_st;
    initial begin
        ctrl_from_net   = 8'h00;
        net_data_out[0] = 32'sd0;
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                c_start_cnt     = 0;
                c_rel_cnt       = 0;
                ctrl_from_net   = 8'h00;
                net_data_out[0] = 32'sd0;
            end else begin
                if (ctrl_to_net[0]) begin
                    c_start_cnt++;
                    c_rel_cnt = 0;
                    c_st      = 2'b01;
                    c_fin     = (cur_fin != 0) && (c_start_cnt >= cur_fin);
                end else begin
                    c_start_cnt = 0;
                    c_fin       = 1'b0;
                    c_st        = (c_rel_cnt < cur_stall) ? 2'b10 : 2'b00;
                    if (c_rel_cnt < cur_stall) c_rel_cnt++;
                end
                // Result is only meaningful while finish is shown; garbage otherwise.
                net_data_out[0] = c_fin ? (net_data_in[0] + net_data_in[1]) : $signed($urandom);
                ctrl_from_net   = {c_st, 5'($urandom), c_fin};
            end
        end
    end

    // Expectation model: one outstanding job, its expected phase lengths and result.
    logic signed [31:0] m_ops [0:INPUT_SIZE-1];
    logic signed [31:0] m_data;
    logic signed [31:0] m_prev;
    bit                 m_to;
    bit                 m_pending;
    bit                 m_resp_seen;
    bit                 m_finished;
    int                 m_start_len;
    int                 m_rel_len;
    int                 start_len;
    int                 rel_len;
    int                 since_acc;
    bit                 in_rel;

    // Compare process: checks every cycle against the model.
    initial begin
        m_ops[0] = 0; m_ops[1] = 0; m_prev = 0; m_data = 0; m_to = 0;
        m_pending = 0; m_resp_seen = 0; start_len = 0; rel_len = 0;
        since_acc = 0; in_rel = 0; m_start_len = 0; m_rel_len = 0;
        forever begin
            @(negedge clk);
            if (!n_rst) begin
                check("rst_req_ready", bus.req_ready, 1);
                check("rst_busy", busy, 0);
                check("rst_resp_valid", bus.resp_valid, 0);
                check("rst_resp_timeout", bus.resp_timeout, 0);
                check("rst_ctrl_to_net", ctrl_to_net, 8'h00);
                check("rst_net_data_in0", net_data_in[0], 0);
                check("rst_net_data_in1", net_data_in[1], 0);
                check("rst_resp_data", bus.resp_data[0], 0);
                m_ops[0] = 0; m_ops[1] = 0; m_prev = 0;
                m_pending = 0; m_resp_seen = 0;
                start_len = 0; rel_len = 0; in_rel = 0; since_acc = 0;
            end else begin
                check("ctrl_upper_zero", ctrl_to_net[7:1], 0);
                check("busy", busy, m_pending);
                check("req_ready", bus.req_ready, !m_pending);
                check("net_data_in0", net_data_in[0], m_ops[0]);
                check("net_data_in1", net_data_in[1], m_ops[1]);

                if (ctrl_to_net[0]) begin
                    if (start_len == 0) check("start_latency", since_acc, 1);
                    start_len++;
                end else if (start_len != 0) begin
                    check("start_len", start_len, m_start_len);
                    start_len = 0;
                    in_rel    = 1;
                    rel_len   = 0;
                end

                if (in_rel) begin
                    if (bus.resp_valid) begin
                        check("release_len", rel_len, m_rel_len);
                        in_rel = 0;
                    end else begin
                        rel_len++;
                    end
                end

                if (m_resp_seen) check("resp_valid_held", bus.resp_valid, 1);
                if (bus.resp_valid) begin
                    m_resp_seen = 1;
                    check("resp_data", bus.resp_data[0], m_data);
                    check("resp_timeout", bus.resp_timeout, m_to);
                    if (bus.resp_ready) begin
                        m_pending   = 0;
                        m_resp_seen = 0;
                        m_prev      = m_data;
                    end
                end

                if (bus.req_valid && bus.req_ready) begin
                    m_ops[0]    = bus.req_data[0];
                    m_ops[1]    = bus.req_data[1];
                    m_finished  = (cur_fin >= 1) && (cur_fin <= TIMEOUT);
                    m_start_len = m_finished ? cur_fin : TIMEOUT;
                    m_data      = m_finished ? (m_ops[0] + m_ops[1]) : m_prev;
                    m_to        = !m_finished || (cur_stall >= TIMEOUT);
                    m_rel_len   = (cur_stall < TIMEOUT) ? cur_stall + 1 : TIMEOUT;
                    m_pending   = 1;
                    since_acc   = 0;
                end
                since_acc++;
            end
        end
    end

    bit stop_run = 0;

    task automatic present(input int i);
        cur_fin         = jobs[i].fin;
        cur_stall       = jobs[i].stall;
        bus.req_data[0] = jobs[i].op0;
        bus.req_data[1] = jobs[i].op1;
        bus.req_valid   = 1'b1;
    endtask

    task automatic wait_accept(input string tag);
        int waits;
        waits = 0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            waits++;
            if (bus.req_ready) break;
        end
        check({tag, "_accept_first_idle"}, waits, 1);
        if (waits != 1) stop_run = 1;
        @(posedge clk); #1;
    endtask

    task automatic run_job(input int i);
        bit seen;
        present(i);
        wait_accept($sformatf("job%0d", i));
        if (stop_run) return;
        bus.req_valid = jobs[i].hold;
        seen = 0;
        for (int c = 0; c < 3000 && !seen; c++) begin
            bus.req_data[0] = $signed($urandom);
            bus.req_data[1] = $signed($urandom);
            @(negedge clk);
            if (bus.resp_valid) seen = 1;
            else begin @(posedge clk); #1; end
        end
        if (!seen) begin
            check($sformatf("job%0d_resp_wait", i), 0, 1);
            stop_run = 1;
            return;
        end
        @(posedge clk); #1;
        if (jobs[i].hold && i < 8) present(i + 1);
        for (int d = 0; d < jobs[i].delay; d++) begin
            @(posedge clk); #1;
            check($sformatf("job%0d_bp_valid", i), bus.resp_valid, 1);
            check($sformatf("job%0d_bp_req_ready", i), bus.req_ready, 0);
        end
        check($sformatf("job%0d_lit_valid", i), bus.resp_valid, 1);
        check($sformatf("job%0d_lit_data", i), bus.resp_data[0], 64'(signed'(jobs[i].exp_data)));
        check($sformatf("job%0d_lit_timeout", i), bus.resp_timeout, jobs[i].exp_to);
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
    endtask

    // Stimulus: reset, directed job table, reset mid-compute, recovery job.
    initial begin
        //          op0 op1  fin  stall delay hold data to
        jobs[0] = '{  3,  5,    0,    0,   0,  0,   0, 1};  // never finishes: timeout, data from reset
        jobs[1] = '{  3,  5,  257,    0,   0,  1,   8, 0};  // normal job, next request held
        jobs[2] = '{ 10, -4,    5,    0,  20,  1,   6, 0};  // backpressure, request held meanwhile
        jobs[3] = '{  2,  2,    3,   50,   0,  0,   4, 0};  // release stall
        jobs[4] = '{  1,  1, 1024,    0,   0,  0,   2, 0};  // finish on last cycle wins
        jobs[5] = '{ -5,  9,    1,    0,   0,  0,   4, 0};  // finish on first start cycle
        jobs[6] = '{  6,  6,    2, 2000,   0,  0,  12, 1};  // controller never returns to idle
        jobs[7] = '{  0,  0,    0,    0,   0,  0,  12, 1};  // timeout keeps previous result
        jobs[8] = '{  7,  1,  257,    0,   0,  0,   8, 0};  // job after mid-compute reset

        n_rst          = 1'b1;
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b0;
        bus.req_data[0] = 0;
        bus.req_data[1] = 0;
        #2 n_rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        present(0);
        n_rst = 1'b1;

        for (int i = 0; i < 8 && !stop_run; i++) begin
            run_job(i);
        end

        if (!stop_run) begin
            // Abort a job at cycle 100 of WAIT_FINISH.
            cur_fin         = 0;
            cur_stall       = 0;
            bus.req_data[0] = 9;
            bus.req_data[1] = 9;
            bus.req_valid   = 1'b1;
            wait_accept("abort");
            bus.req_valid = 1'b0;
            repeat (100) @(posedge clk);
            #1;
            check("abort_start_before", ctrl_to_net, 8'h01);
            n_rst = 1'b0;
            #1;
            check("abort_ctrl_to_net", ctrl_to_net, 8'h00);
            check("abort_busy", busy, 0);
            check("abort_resp_valid", bus.resp_valid, 0);
            check("abort_req_ready", bus.req_ready, 1);
            repeat (3) @(posedge clk);
            #1;
            n_rst = 1'b1;
            run_job(8);
        end

        repeat (5) @(posedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
